// File: rtl/descriptor_mem_pkg.sv
// Shared constants, FSM/grant encodings and the DMA burst-length clamp for the
// descriptor RAM arbiter.
package descriptor_mem_pkg;

  localparam int ADDR_W    = 11;
  localparam int DATA_W    = 32;
  localparam int BE_W      = 4;
  localparam int MAX_BURST = 8;
  localparam int BURST_W   = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_DMA = 1'b1
  } grant_e;

  // A zero burstcount still fetches one word; oversize requests are cut to MAX_BURST.
  function automatic logic [BURST_W-1:0] clamp_burst(input logic [BURST_W-1:0] bc);
    if (bc == '0) return BURST_W'(1);
    if (bc > BURST_W'(MAX_BURST)) return BURST_W'(MAX_BURST);
    return bc;
  endfunction

endpackage

// File: rtl/descriptor_mem_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter: combinational grant, history updated only
// when the granted request is actually accepted.
module rr_arb2
  import descriptor_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_gnt,
  output logic       o_last_grant
);

  grant_e r_last_grant;

  // bit 0 = CPU, bit 1 = DMA; on a tie the port that did not win last time goes.
  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = (r_last_grant == GNT_DMA) ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= GNT_DMA;
    end else if (i_accept) begin
      r_last_grant <= o_gnt[1] ? GNT_DMA : GNT_CPU;
    end
  end

  assign o_last_grant = (r_last_grant == GNT_DMA);

endmodule

// File: rtl/descriptor_mem_arbiter.sv
// Shares the single-port 2048x32 descriptor RAM between the CPU slave path and the
// DMA descriptor fetcher; DMA read bursts lock the RAM until the last beat.
module descriptor_mem_arbiter
  import descriptor_mem_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   cpu_address,
  input  logic [BE_W-1:0]     cpu_byteenable,
  input  logic                cpu_read,
  input  logic                cpu_write,
  input  logic [DATA_W-1:0]   cpu_writedata,
  output logic                cpu_waitrequest,
  output logic [DATA_W-1:0]   cpu_readdata,
  output logic                cpu_readdatavalid,
  input  logic [ADDR_W-1:0]   dma_address,
  input  logic [BURST_W-1:0]  dma_burstcount,
  input  logic                dma_read,
  input  logic                dma_write,
  input  logic [DATA_W-1:0]   dma_writedata,
  output logic                dma_waitrequest,
  output logic [DATA_W-1:0]   dma_readdata,
  output logic                dma_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [BE_W-1:0]     mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic [1:0]          o_dbg_status
);

  // Handshake: a request (read or write high) is accepted in the cycle where its
  // waitrequest is low; the requester must hold it stable until then. Read data
  // follows one cycle after each issued beat, qualified only by readdatavalid.

  state_e               r_state, w_state_nxt;
  logic                 r_rdy;
  logic [ADDR_W-1:0]    r_addr, w_addr_nxt;
  logic [BURST_W-1:0]   r_beats, w_beats_nxt;
  logic                 r_cpu_rvalid, r_dma_rvalid;
  logic                 w_cpu_rd_beat, w_dma_rd_beat;
  logic                 w_cpu_req, w_dma_req, w_open, w_accept, w_last_grant;
  logic [1:0]           w_req, w_gnt;
  logic [BURST_W-1:0]   w_len;

  assign w_cpu_req = cpu_read | cpu_write;
  assign w_dma_req = dma_read | dma_write;
  assign w_open    = r_rdy && (r_state == IDLE);
  assign w_req     = w_open ? {w_dma_req, w_cpu_req} : 2'b00;
  assign w_accept  = |w_req;

  rr_arb2 u_arb (
    .clk          (clk),
    .rst_n        (reset_n),
    .i_req        (w_req),
    .i_accept     (w_accept),
    .o_gnt        (w_gnt),
    .o_last_grant (w_last_grant)
  );

  assign cpu_waitrequest = ~w_gnt[0];
  assign dma_waitrequest = ~w_gnt[1];

  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_beats_nxt    = r_beats;
    mem_address    = '0;
    mem_byteenable = '0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = '0;
    w_cpu_rd_beat  = 1'b0;
    w_dma_rd_beat  = 1'b0;
    w_len          = clamp_burst(dma_burstcount);
    case (r_state)
      IDLE: begin
        if (w_gnt[0]) begin
          // read+write together is taken as a write
          mem_address    = cpu_address;
          mem_byteenable = cpu_byteenable;
          mem_chipselect = 1'b1;
          mem_write      = cpu_write;
          mem_writedata  = cpu_writedata;
          w_cpu_rd_beat  = ~cpu_write;
        end else if (w_gnt[1]) begin
          mem_address    = dma_address;
          mem_byteenable = '1;
          mem_chipselect = 1'b1;
          mem_write      = dma_write;
          mem_writedata  = dma_writedata;
          if (!dma_write) begin
            w_dma_rd_beat = 1'b1;
            if (w_len > BURST_W'(1)) begin
              w_state_nxt = BURST;
              w_addr_nxt  = dma_address + ADDR_W'(1);
              w_beats_nxt = w_len - BURST_W'(1);
            end
          end
        end
      end
      BURST: begin
        // address wraps naturally at ADDR_W bits
        mem_address    = r_addr;
        mem_byteenable = '1;
        mem_chipselect = 1'b1;
        w_dma_rd_beat  = 1'b1;
        w_addr_nxt     = r_addr + ADDR_W'(1);
        w_beats_nxt    = r_beats - BURST_W'(1);
        if (r_beats == BURST_W'(1)) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_rdy        <= 1'b0;
      r_addr       <= '0;
      r_beats      <= '0;
      r_cpu_rvalid <= 1'b0;
      r_dma_rvalid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_rdy        <= 1'b1;
      r_addr       <= w_addr_nxt;
      r_beats      <= w_beats_nxt;
      r_cpu_rvalid <= w_cpu_rd_beat;
      r_dma_rvalid <= w_dma_rd_beat;
    end
  end

  assign cpu_readdata      = mem_readdata;
  assign dma_readdata      = mem_readdata;
  assign cpu_readdatavalid = r_cpu_rvalid;
  assign dma_readdatavalid = r_dma_rvalid;
  assign o_dbg_status      = {w_last_grant, r_state};

endmodule

// File: tb/tb_descriptor_mem_arbiter.sv
// Self-checking bench for descriptor_mem_arbiter: behavioural RAM, transaction-level
// arbitration model and a read-data scoreboard, directed cases plus random traffic.
module tb_descriptor_mem_arbiter;
  import descriptor_mem_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic [10:0] cpu_address, dma_address, mem_address;
  logic [3:0]  cpu_byteenable, dma_burstcount, mem_byteenable;
  logic        cpu_read, cpu_write, cpu_waitrequest, cpu_readdatavalid;
  logic        dma_read, dma_write, dma_waitrequest, dma_readdatavalid;
  logic        mem_chipselect, mem_write;
  logic [31:0] cpu_writedata, cpu_readdata, dma_writedata, dma_readdata;
  logic [31:0] mem_writedata, mem_readdata;
  logic [1:0]  dbg_status;

  descriptor_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_address(cpu_address), .cpu_byteenable(cpu_byteenable), .cpu_read(cpu_read),
    .cpu_write(cpu_write), .cpu_writedata(cpu_writedata), .cpu_waitrequest(cpu_waitrequest),
    .cpu_readdata(cpu_readdata), .cpu_readdatavalid(cpu_readdatavalid),
    .dma_address(dma_address), .dma_burstcount(dma_burstcount), .dma_read(dma_read),
    .dma_write(dma_write), .dma_writedata(dma_writedata), .dma_waitrequest(dma_waitrequest),
    .dma_readdata(dma_readdata), .dma_readdatavalid(dma_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .o_dbg_status(dbg_status)
  );

  // RAM: 1-cycle read latency, byte-lane writes
  logic [31:0] ram [0:2047];
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  // ---------------- model / scoreboard state ----------------
  logic [31:0] model_mem [0:2047];
  logic [31:0] exp_cpu_q[$];
  logic [31:0] exp_dma_q[$];
  int unsigned due_cpu_q[$];
  int unsigned due_dma_q[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          busy = 0;
  logic [10:0] b_addr = '0;
  logic        last_win = 1'b1;  // 1 = DMA won last
  logic        unready = 1'b1;
  logic [31:0] last_cpu_rdata = '0;
  logic        cpu_acc, dma_acc;

  // driver intent
  logic        cpu_pend = 0, cpu_wr = 0, c_both = 0;
  logic [10:0] c_addr = '0;
  logic [3:0]  c_be = '0;
  logic [31:0] c_wd = '0;
  logic        dma_pend = 0, dma_wr = 0;
  logic [10:0] d_addr = '0;
  logic [3:0]  d_bc = '0;
  logic [31:0] d_wd = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_write(input logic [10:0] a, input logic [3:0] be, input logic [31:0] d);
    for (int b = 0; b < 4; b++)
      if (be[b]) model_mem[a][b*8 +: 8] = d[b*8 +: 8];
  endtask

  // One bus cycle: check read returns, drive pins, predict and check the accept.
  task automatic step();
    logic e, e_cpu, e_dma;
    int   len;
    logic [10:0] a;
    @(negedge clk);
    cyc++;
    e = (due_cpu_q.size() > 0) && (due_cpu_q[0] == cyc);
    chk("cpu_rvalid", 32'(cpu_readdatavalid), 32'(e));
    if (e) begin
      chk("cpu_rdata", cpu_readdata, exp_cpu_q.pop_front());
      last_cpu_rdata = cpu_readdata;
      due_cpu_q.delete(0);
    end
    e = (due_dma_q.size() > 0) && (due_dma_q[0] == cyc);
    chk("dma_rvalid", 32'(dma_readdatavalid), 32'(e));
    if (e) begin
      chk("dma_rdata", dma_readdata, exp_dma_q.pop_front());
      due_dma_q.delete(0);
    end

    cpu_read       = cpu_pend & (~cpu_wr | c_both);
    cpu_write      = cpu_pend & cpu_wr;
    cpu_address    = c_addr;
    cpu_byteenable = c_be;
    cpu_writedata  = c_wd;
    dma_read       = dma_pend & ~dma_wr;
    dma_write      = dma_pend & dma_wr;
    dma_address    = d_addr;
    dma_burstcount = d_bc;
    dma_writedata  = d_wd;
    #1;
    cpu_acc = cpu_pend & ~cpu_waitrequest;
    dma_acc = dma_pend & ~dma_waitrequest;

    e_cpu = 1'b0;
    e_dma = 1'b0;
    if (!unready && busy == 0) begin
      if (cpu_pend && dma_pend) begin
        e_cpu = last_win;
        e_dma = ~last_win;
      end else begin
        e_cpu = cpu_pend;
        e_dma = dma_pend;
      end
    end
    chk("cpu_accept", 32'(cpu_acc), 32'(e_cpu));
    chk("dma_accept", 32'(dma_acc), 32'(e_dma));

    if (busy > 0) begin
      chk("burst_cs", 32'(mem_chipselect), 32'(1));
      chk("burst_we", 32'(mem_write), 32'(0));
      chk("burst_addr", 32'(mem_address), 32'(b_addr));
      chk("burst_wait", 32'({cpu_waitrequest, dma_waitrequest}), 32'(3));
      busy--;
      b_addr++;
    end else if (e_cpu) begin
      chk("cpu_cs", 32'(mem_chipselect), 32'(1));
      chk("cpu_maddr", 32'(mem_address), 32'(c_addr));
      chk("cpu_we", 32'(mem_write), 32'(cpu_wr));
      last_win = 1'b0;
      if (cpu_wr) begin
        chk("cpu_be", 32'(mem_byteenable), 32'(c_be));
        chk("cpu_wdata", mem_writedata, c_wd);
        model_write(c_addr, c_be, c_wd);
      end else begin
        exp_cpu_q.push_back(model_mem[c_addr]);
        due_cpu_q.push_back(cyc + 1);
      end
    end else if (e_dma) begin
      chk("dma_cs", 32'(mem_chipselect), 32'(1));
      chk("dma_maddr", 32'(mem_address), 32'(d_addr));
      chk("dma_we", 32'(mem_write), 32'(dma_wr));
      last_win = 1'b1;
      if (dma_wr) begin
        chk("dma_be", 32'(mem_byteenable), 32'hF);
        chk("dma_wdata", mem_writedata, d_wd);
        model_write(d_addr, 4'hF, d_wd);
      end else begin
        len = (d_bc == 0) ? 1 : ((d_bc > 8) ? 8 : int'(d_bc));
        for (int k = 0; k < len; k++) begin
          a = d_addr + 11'(k);
          exp_dma_q.push_back(model_mem[a]);
          due_dma_q.push_back(cyc + 1 + 32'(k));
        end
        busy   = len - 1;
        b_addr = d_addr + 11'd1;
      end
    end else begin
      chk("idle_cs", 32'(mem_chipselect), 32'(0));
      chk("idle_we", 32'(mem_write), 32'(0));
    end
    if (cpu_acc) cpu_pend = 1'b0;
    if (dma_acc) dma_pend = 1'b0;
    unready = 1'b0;
  endtask

  task automatic run_done(input int bound);
    int n;
    n = 0;
    while ((cpu_pend || dma_pend || busy > 0 || exp_cpu_q.size() > 0 || exp_dma_q.size() > 0)
           && n < bound) begin
      step();
      n++;
    end
    chk("done_in_time", 32'(n < bound), 32'(1));
  endtask

  task automatic step_until_dma(input int bound);
    int n;
    n = 0;
    dma_acc = 1'b0;
    while (!dma_acc && n < bound) begin
      step();
      n++;
    end
    chk("dma_accept_in_time", 32'(dma_acc), 32'(1));
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    cpu_pend = 1'b0;
    dma_pend = 1'b0;
    cpu_read = 1'b1;   // requests during reset must still be held off
    dma_read = 1'b1;
    #1;
    chk("rst_cpu_wait", 32'(cpu_waitrequest), 32'(1));
    chk("rst_dma_wait", 32'(dma_waitrequest), 32'(1));
    chk("rst_cpu_rvalid", 32'(cpu_readdatavalid), 32'(0));
    chk("rst_dma_rvalid", 32'(dma_readdatavalid), 32'(0));
    chk("rst_cs", 32'(mem_chipselect), 32'(0));
    chk("rst_we", 32'(mem_write), 32'(0));
    cpu_read = 1'b0;
    dma_read = 1'b0;
    exp_cpu_q.delete();
    exp_dma_q.delete();
    due_cpu_q.delete();
    due_dma_q.delete();
    busy     = 0;
    last_win = 1'b1;
    unready  = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic set_cpu(input logic wr, input logic [10:0] a, input logic [3:0] be, input logic [31:0] d);
    cpu_pend = 1'b1; cpu_wr = wr; c_both = 1'b0; c_addr = a; c_be = be; c_wd = d;
  endtask

  task automatic set_dma(input logic wr, input logic [10:0] a, input logic [3:0] bc, input logic [31:0] d);
    dma_pend = 1'b1; dma_wr = wr; d_addr = a; d_bc = bc; d_wd = d;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] orig3;
    logic [31:0] v;
    cpu_read = 0; cpu_write = 0; cpu_address = '0; cpu_byteenable = '0; cpu_writedata = '0;
    dma_read = 0; dma_write = 0; dma_address = '0; dma_burstcount = '0; dma_writedata = '0;
    for (int i = 0; i < 2048; i++) begin
      v = $urandom;
      ram[i] <= v;
      model_mem[i] = v;
    end
    do_reset();

    // CPU read right after reset: held one cycle, then accepted
    set_cpu(1'b0, 11'd5, 4'hF, 32'h0);
    step();
    chk("first_cycle_held", 32'(cpu_waitrequest), 32'(1));
    run_done(10);

    // partial byte-lane write then read back
    orig3 = model_mem[3];
    set_cpu(1'b1, 11'd3, 4'b1100, 32'hA5A5_0000);
    run_done(10);
    set_cpu(1'b0, 11'd3, 4'hF, 32'h0);
    run_done(10);
    chk("be_merge", last_cpu_rdata, {16'hA5A5, orig3[15:0]});

    // wrapping burst with a CPU read waiting behind it
    set_dma(1'b0, 11'd2046, 4'd4, 32'h0);
    step_until_dma(10);
    set_cpu(1'b0, 11'd7, 4'hF, 32'h0);
    run_done(20);

    // burstcount clamps
    set_dma(1'b0, 11'd40, 4'd0, 32'h0);
    run_done(20);
    set_dma(1'b0, 11'd60, 4'd15, 32'h0);
    run_done(30);

    // reset during beat 2 of an 8-beat burst
    set_dma(1'b0, 11'd100, 4'd8, 32'h0);
    step_until_dma(10);
    step();
    step();
    chk("pre_rst_rvalid", 32'(dma_readdatavalid), 32'(1));
    reset_n = 1'b0;
    #1;
    chk("midrst_rvalid", 32'(dma_readdatavalid), 32'(0));
    chk("midrst_cs", 32'(mem_chipselect), 32'(0));
    do_reset();
    repeat (10) step();

    // tie from reset: CPU first, DMA on the next tie
    set_cpu(1'b0, 11'd9, 4'hF, 32'h0);
    set_dma(1'b1, 11'd20, 4'd1, 32'hDEAD_BEEF);
    step();
    chk("tie1_cpu", 32'(cpu_acc), 32'(1));
    chk("tie1_dma", 32'(dma_acc), 32'(0));
    set_cpu(1'b0, 11'd10, 4'hF, 32'h0);
    step();
    chk("tie2_dma", 32'(dma_acc), 32'(1));
    chk("tie2_cpu", 32'(cpu_acc), 32'(0));
    run_done(20);

    // random mixed traffic
    for (int i = 0; i < 800; i++) begin
      if (!cpu_pend && $urandom_range(0, 2) == 0) begin
        set_cpu($urandom_range(0, 1) == 1,
                ($urandom_range(0, 1) == 1) ? 11'($urandom_range(2040, 2047)) : 11'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), $urandom);
        c_both = ($urandom_range(0, 3) == 0);
      end
      if (!dma_pend && $urandom_range(0, 2) == 0)
        set_dma($urandom_range(0, 3) == 0,
                ($urandom_range(0, 1) == 1) ? 11'($urandom_range(2040, 2047)) : 11'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), $urandom);
      step();
    end
    run_done(100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
